// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore sequencing controller for the multicycle MIPS datapath. Each
// instruction walks FETCH -> DECODE -> (execute/memory/writeback) -> FETCH,
// taking 2 to 5 cycles. Outputs come from the current state alone, except
// pcen (qualified by the ALU zero flag) and alucontrl in RTYPEEX (uses funct).
// There is no valid/ready handshake: op/funct are held stable by the
// instruction register from the cycle after FETCH until the next FETCH.
module mips_multicycle_ctrl #(
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int STATE_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [5:0]                op,
  input  logic [5:0]                funct,
  input  logic                      zero,
  output logic                      pcen,
  output logic                      iord,
  output logic                      irwrite,
  output logic                      memwrite,
  output logic                      memtoreg,
  output logic                      regdst,
  output logic                      regwrite,
  output logic                      alusrca,
  output logic [1:0]                alusrcb,
  output logic [1:0]                pcsrc,
  output logic [ALU_CTRL_WIDTH-1:0] alucontrl,
  output logic [STATE_WIDTH-1:0]    state
);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH   = STATE_WIDTH'(0),
    DECODE  = STATE_WIDTH'(1),
    MEMADR  = STATE_WIDTH'(2),
    MEMRD   = STATE_WIDTH'(3),
    MEMWB   = STATE_WIDTH'(4),
    MEMWR   = STATE_WIDTH'(5),
    RTYPEEX = STATE_WIDTH'(6),
    RTYPEWB = STATE_WIDTH'(7),
    BEQEX   = STATE_WIDTH'(8),
    ADDIEX  = STATE_WIDTH'(9),
    ADDIWB  = STATE_WIDTH'(10),
    JEX     = STATE_WIDTH'(11)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b110);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b111);

  state_t state_q;
  state_t state_d;
  logic   pcwrite;
  logic   branch;

  // State register; reset lands in FETCH so the first edge after release fetches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unknown opcodes and unused encodings fall back to FETCH.
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  // Output decode from the current state; defaults first, then per-state overrides.
  always_comb begin
    pcwrite   = 1'b0;
    branch    = 1'b0;
    iord      = 1'b0;
    irwrite   = 1'b0;
    memwrite  = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    pcsrc     = 2'b00;
    alucontrl = ALU_ADD;
    case (state_q)
      FETCH: begin
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = 2'b01;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        alusrcb = 2'b11;
      end
      MEMADR, ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        case (funct)
          FN_ADD:  alucontrl = ALU_ADD;
          FN_SUB:  alucontrl = ALU_SUB;
          FN_AND:  alucontrl = ALU_AND;
          FN_OR:   alucontrl = ALU_OR;
          FN_SLT:  alucontrl = ALU_SLT;
          default: alucontrl = ALU_ADD;
        endcase
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX: begin
        alusrca   = 1'b1;
        alucontrl = ALU_SUB;
        pcsrc     = 2'b01;
        branch    = 1'b1;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-instruction state walks and
// output vectors are predicted from the instruction's class and compared
// each cycle; random instruction streams exercise all paths and zero values.
module tb_mips_multicycle_ctrl;

  localparam int W = 19;  // {state[3:0], pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca, alusrcb[1:0], pcsrc[1:0], alucontrl[2:0]}

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef int seq_t[$];

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrl;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  mips_multicycle_ctrl #(.ALU_CTRL_WIDTH(3), .STATE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrl(alucontrl), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] observed();
    return {state, pcen, iord, irwrite, memwrite, memtoreg, regdst, regwrite,
            alusrca, alusrcb, pcsrc, alucontrl};
  endfunction

  // ---------------- reference model ----------------
  // Sequence of states an instruction visits, FETCH included.
  function automatic seq_t states_for(logic [5:0] o);
    case (o)
      OP_LW:    return '{0, 1, 2, 3, 4};
      OP_SW:    return '{0, 1, 2, 5};
      OP_RTYPE: return '{0, 1, 6, 7};
      OP_BEQ:   return '{0, 1, 8};
      OP_ADDI:  return '{0, 1, 9, 10};
      OP_J:     return '{0, 1, 11};
      default:  return '{0, 1};
    endcase
  endfunction

  // Expected output vector for a given state, funct and zero.
  function automatic logic [W-1:0] model(int st, logic [5:0] f, logic z);
    logic pw, br, io, irw, mw, m2r, rd, rw, asa;
    logic [1:0] asb, ps;
    logic [2:0] alu;
    logic pe;
    logic [3:0] s4;
    pw = 0; br = 0; io = 0; irw = 0; mw = 0; m2r = 0; rd = 0; rw = 0; asa = 0;
    asb = 2'b00; ps = 2'b00; alu = 3'b010;
    case (st)
      0:  begin irw = 1; pw = 1; asb = 2'b01; end
      1:  asb = 2'b11;
      2, 9: begin asa = 1; asb = 2'b10; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin
            asa = 1;
            if (f == 6'b100000) alu = 3'b010;
            else if (f == 6'b100010) alu = 3'b110;
            else if (f == 6'b100100) alu = 3'b000;
            else if (f == 6'b100101) alu = 3'b001;
            else if (f == 6'b101010) alu = 3'b111;
            else alu = 3'b010;
          end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; alu = 3'b110; ps = 2'b01; br = 1; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    pe = pw | (br & z);
    s4 = st[3:0];
    return {s4, pe, io, irw, mw, m2r, rd, rw, asa, asb, ps, alu};
  endfunction

  // ---------------- driver ----------------
  // Entry: just after a rising edge with the DUT in FETCH. Exit: same point,
  // one instruction later. zmode: 0 = zero low, 1 = zero high, 2 = random.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input string name, output int mw_cnt, output int rw_cnt);
    seq_t seq;
    logic [W-1:0] exp_v, got_v;
    mw_cnt = 0;
    rw_cnt = 0;
    op = o;
    funct = f;
    seq = states_for(o);
    foreach (seq[i]) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      exp_q.push_back(model(seq[i], f, zero));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      got_v = observed();
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s step%0d: got %h expected %h (op=%b funct=%b zero=%b)",
                 name, i, got_v, exp_v, o, f, zero);
      end
      if (memwrite === 1'b1) mw_cnt++;
      if (regwrite === 1'b1) rw_cnt++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL %s_return: got state %0d expected 0", name, state);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] exp_v;
    rst_n = 1'b0;
    op = OP_SW;
    funct = 6'b0;
    zero = 1'b0;
    #3;
    exp_v = model(0, funct, zero);
    n_cmp++;
    if (observed() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", observed(), exp_v);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 4'd5 || memwrite !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reach_memwr: got state %0d memwrite %b expected 5/1", state, memwrite);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = model(0, funct, zero);
    n_cmp++;
    if (observed() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", observed(), exp_v);
    end
    @(negedge clk);
    n_cmp++;
    if (state !== 4'd0 || memwrite !== 1'b0 || regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got state %0d mw %b rw %b expected 0/0/0", state, memwrite, regwrite);
    end
    @(posedge clk); #1;
    op = 6'b111111;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_release: got state %0d expected 1", state);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_nop_return: got state %0d expected 0", state);
    end
  endtask

  task automatic test_lw();
    int mw, rw;
    run_instr(OP_LW, 6'($urandom), 2, "lw", mw, rw);
  endtask

  task automatic test_beq();
    int mw, rw;
    run_instr(OP_BEQ, 6'($urandom), 1, "beq_z1", mw, rw);
    run_instr(OP_BEQ, 6'($urandom), 0, "beq_z0", mw, rw);
    run_instr(OP_RTYPE, 6'b100000, 1, "rtype_z1", mw, rw);
  endtask

  task automatic test_rtype();
    int mw, rw;
    run_instr(OP_RTYPE, 6'b101010, 2, "rtype_slt", mw, rw);
    run_instr(OP_RTYPE, 6'b100010, 2, "rtype_sub", mw, rw);
    run_instr(OP_RTYPE, 6'b111111, 2, "rtype_other", mw, rw);
    run_instr(OP_RTYPE, 6'b100100, 2, "rtype_and", mw, rw);
    run_instr(OP_RTYPE, 6'b100101, 2, "rtype_or", mw, rw);
  endtask

  task automatic test_j_unknown();
    int mw, rw;
    run_instr(OP_J, 6'($urandom), 2, "j", mw, rw);
    run_instr(6'b111111, 6'($urandom), 2, "unknown", mw, rw);
    n_cmp++;
    if (mw != 0 || rw != 0) begin
      n_fail++;
      $display("FAIL unknown_writes: got mw %0d rw %0d expected 0/0", mw, rw);
    end
  endtask

  task automatic test_back_to_back();
    int cycles, fetches, mw, rw;
    cycles = 0; fetches = 0; mw = 0; rw = 0;
    op = OP_SW;
    funct = 6'($urandom);
    // Count cycles until the third FETCH (start of the instruction after addi).
    for (int i = 0; i < 20 && fetches < 3; i++) begin
      zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (state === 4'd0) begin
        fetches++;
        if (fetches == 2) op = OP_ADDI;
      end
      if (fetches < 3) begin
        cycles++;
        if (memwrite === 1'b1) mw++;
        if (regwrite === 1'b1) rw++;
        @(posedge clk); #1;
      end
    end
    n_cmp++;
    if (fetches != 3) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d fetches expected 3", fetches);
    end
    n_cmp++;
    if (cycles != 8) begin
      n_fail++;
      $display("FAIL b2b_cycles: got %0d expected 8", cycles);
    end
    n_cmp++;
    if (mw != 1 || rw != 1) begin
      n_fail++;
      $display("FAIL b2b_pulses: got mw %0d rw %0d expected 1/1", mw, rw);
    end
    // Finish in a clean FETCH cycle boundary for the following test.
    op = 6'b111111;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops[7];
    logic [5:0] fns[6];
    logic [5:0] o, f;
    int mw, rw, emw, erw;
    seq_t seq;
    ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, 6'b0};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b0};
    for (int n = 0; n < 200; n++) begin
      o = (n % 7 == 6) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run_instr(o, f, 2, "random", mw, rw);
      seq = states_for(o);
      emw = (seq.size() == 4 && seq[3] == 5) ? 1 : 0;
      erw = (o == OP_LW || o == OP_RTYPE || o == OP_ADDI) ? 1 : 0;
      n_cmp++;
      if (mw != emw || rw != erw) begin
        n_fail++;
        $display("FAIL random_pulses: op %b got mw %0d rw %0d expected %0d/%0d", o, mw, rw, emw, erw);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_rtype();
    test_j_unknown();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style sequencing controller for the multicycle build of the MIPS core. It takes the opcode and funct fields from the datapath's instruction register plus the ALU `zero` flag. It drives every enable and mux select the shared-ALU, shared-memory datapath needs, taking each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles. It sits inside the core beside the multicycle datapath and replaces the single-cycle controller.

## Interface
- `ALU_CTRL_WIDTH`, default 3: ALU control width. Encodings: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `STATE_WIDTH`, default 4: width of the state register and the debug port.
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `op`, in, 6: instr[31:26] from the instruction register.
- `funct`, in, 6: instr[5:0] from the instruction register.
- `zero`, in, 1: ALU result == 0.
- `pcen`, out, 1: PC register enable; equals `pcwrite | (branch & zero)`.
- `iord`, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- `irwrite`, out, 1: instruction register load enable.
- `memwrite`, out, 1: memory write strobe.
- `memtoreg`, out, 1: writeback data select; 1 = data register, 0 = ALUOut.
- `regdst`, out, 1: destination register select; 1 = rd, 0 = rt.
- `regwrite`, out, 1: register file write enable.
- `alusrca`, out, 1: ALU A select; 0 = PC, 1 = register A.
- `alusrcb`, out, 2: ALU B select; 00 = register B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc`, out, 2: next-PC select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrl`, out, `ALU_CTRL_WIDTH`: ALU operation.
- `state`, out, `STATE_WIDTH`: current state, for debug and verification.

## Operation
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
- Transitions:
  - FETCH→DECODE.
  - DECODE on `op`: 100011 (lw) or 101011 (sw) → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX; any other opcode → FETCH (treated as NOP).
  - MEMADR: lw → MEMRD, sw → MEMWR, based on `op` re-sampled in MEMADR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB, ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
  - Unused encodings 12–15 → FETCH; all outputs at their defaults while in them.
- Outputs are decoded from `state` only, except `pcen` (uses `zero`) and `alucontrl` in RTYPEEX (uses `funct`).
- Defaults: all 1-bit outputs 0, `alusrcb`=00, `pcsrc`=00, `alucontrl`=010. Per-state overrides:
  - FETCH: `irwrite`=1, `pcwrite`=1, `alusrcb`=01.
  - DECODE: `alusrcb`=11 (branch target precompute).
  - MEMADR, ADDIEX: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `iord`=1, `memwrite`=1.
  - RTYPEEX: `alusrca`=1, `alucontrl` from `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→010.
  - RTYPEWB: `regwrite`=1, `regdst`=1.
  - BEQEX: `alusrca`=1, `alucontrl`=110, `pcsrc`=01, `branch`=1.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- `pcwrite` and `branch` are internal signals, not ports.
- `zero` has no effect outside BEQEX.

## Timing
- Asynchronous reset forces `state`=FETCH immediately. Outputs then show FETCH values: `irwrite`=1, `pcen`=1, `alusrcb`=01, everything else at default. The first fetch completes on the first rising edge after `rst_n` deasserts.
- Reset asserted mid-instruction abandons it. No `memwrite` or `regwrite` pulse follows assertion.
- Instruction latencies, FETCH to FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2 cycles.
- `memwrite` and `regwrite` are single-cycle pulses, exactly one per sw, or per lw/R/addi, respectively.
- `op` and `funct` are stable from the cycle after FETCH until the next FETCH. The controller does not register them.

## Test plan
- Reset: `rst_n`=0 mid-MEMWR → `state`=0 without waiting for a clock edge, `memwrite`=0. Release → DECODE after 1 edge.
- lw (`op`=100011) → states 0,1,2,3,4,0. `iord`=1 only in state 3. `regwrite`=`memtoreg`=1 only in state 4.
- beq (`op`=000100): `zero`=1 → `pcen`=1 in state 8 with `pcsrc`=01. `zero`=0 → `pcen`=0. Toggling `zero` in state 6 has no effect on `pcen`.
- R-type (`op`=0), `funct`=101010 → `alucontrl`=111 in state 6. Then `regdst`=`regwrite`=1 in state 7. Repeat for 100010 → 110 and 111111 → 010.
- j (`op`=000010) → state 11 with `pcsrc`=10, `pcen`=1, then FETCH. Unknown `op`=111111 → DECODE→FETCH, no writes.
- Back-to-back sw then addi → exactly one `memwrite` pulse and one `regwrite` pulse, 8 cycles total.
